// File: rtl/mem_pkg.sv
// Shared definitions for the single-port RAM request controller.
// Holds the response-buffer sizing and the request opcode encoding.
package mem_pkg;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/fifo2.sv
// Two-entry response buffer with registered head output.
// Latency: push visible on pop_data one cycle later; push+pop in one cycle keeps count and order.
// Backpressure: push is dropped when full without a same-cycle pop; pop ignored when empty.
module fifo2
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0]    mem [RSP_DEPTH];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [RSP_CNT_W-1:0] count;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == RSP_CNT_W'(RSP_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + RSP_CNT_W'(1);
                2'b01:   count <= count - RSP_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, read-first, one-cycle registered read data.
// Latency: rdata valid one cycle after addr is presented.
// Backpressure: none; accepts an access every cycle.
module ram_sp_sync #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_sp_req_ctrl.sv
// Valid/ready request front-end for a single-port synchronous RAM with in-order read responses.
// Latency: read response two cycles after accept; writes complete in the accept cycle, no response.
// Backpressure: req_ready_o drops once two reads are in flight/buffered, unless a response pops this cycle.
module ram_sp_req_ctrl
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    logic accept;
    logic rd_accept;
    logic rd_pend;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic occ_full;

    assign accept    = req_valid_i & req_ready_o;
    assign rd_accept = accept & (op_e'(req_we_i) == OP_READ);
    assign pop       = rsp_valid_o & rsp_ready_i;

    // Occupancy (buffered + in-flight) reaches two when full, or one buffered plus one in flight.
    assign occ_full    = fifo_full | (~fifo_empty & rd_pend);
    assign req_ready_o = ~occ_full | pop;

    assign ram_wen_o   = accept & req_we_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_accept;
        end
    end

    assign rsp_valid_o = ~fifo_empty;

    fifo2 #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .push      (rd_pend),
        .push_data (ram_rdata_i),
        .pop       (pop),
        .pop_data  (rsp_rdata_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ram_sp_req_ctrl.sv
// Bench for ram_sp_req_ctrl driving a ram_sp_sync; read data is checked against a reference memory
// through a scoreboard queue filled on read accept and drained on response handshake.
module tb_ram_sp_req_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int wen_cnt  = 0;
    bit rand_done;

    logic [DW-1:0] exp_q [$];
    int            rsp_cyc_q [$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rsp;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    ram_sp_req_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .ram_wen_o   (ram_wen_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    ram_sp_sync #(.DATA_W(DW), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .wen   (ram_wen_o),
        .addr  (ram_addr_o),
        .wdata (ram_wdata_o),
        .rdata (ram_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard and per-cycle interface monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_ni !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (ram_wen_o !== (req_valid_i & req_ready_o & req_we_i) ||
                ram_addr_o !== req_addr_i || ram_wdata_o !== req_wdata_i) begin
                failures++;
                $display("FAIL ram_if wen=%b addr=%h wdata=%h required wen=%b addr=%h wdata=%h", ram_wen_o,
                         ram_addr_o, ram_wdata_o, req_valid_i & req_ready_o & req_we_i, req_addr_i, req_wdata_i);
            end
            if (ram_wen_o === 1'b1) wen_cnt++;
            if (prev_stall) begin
                checks++;
                if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== prev_data) begin
                    failures++;
                    $display("FAIL rsp_stable valid=%b data=%h required valid=1 data=%h", rsp_valid_o, rsp_rdata_o, prev_data);
                end
            end
            prev_stall = rsp_valid_o & ~rsp_ready_i;
            prev_data  = rsp_rdata_o;
            if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
                checks++;
                rsp_cnt++;
                rsp_cyc_q.push_back(cyc);
                last_rsp = rsp_rdata_o;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected data=%h required no response", rsp_rdata_o);
                end else begin
                    logic [DW-1:0] exp_d;
                    exp_d = exp_q.pop_front();
                    if (rsp_rdata_o !== exp_d) begin
                        failures++;
                        $display("FAIL rsp_data got=%h required=%h", rsp_rdata_o, exp_d);
                    end
                end
            end
            if (req_valid_i === 1'b1 && req_ready_o === 1'b1) begin
                if (req_we_i) ref_mem[req_addr_i] = req_wdata_i;
                else          exp_q.push_back(ref_mem[req_addr_i]);
            end
            checks++;
            if (exp_q.size() > 2) begin
                failures++;
                $display("FAIL occupancy outstanding=%0d required<=2", exp_q.size());
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        waited      = 0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        @(negedge clk);
        while (req_ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout addr=%h ready=%b required=1", a, req_ready_o);
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready_i = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid_o !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d valid=%b required pending=0 valid=0", exp_q.size(), rsp_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || ram_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b ready=%b wen=%b required 0 1 0", rsp_valid_o, req_ready_o, ram_wen_o);
        end
        @(negedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset valid=%b ready=%b required 0 1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_write_read();
        int w;
        int base;
        rsp_ready_i = 1'b1;
        issue(1'b1, AW'('h10), 32'hDEAD_BEEF, w);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = AW'('h10);
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL wr_rd_ready got=%b required=1", req_ready_o);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        base = rsp_cnt;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL latency_early valid=%b required=0", rsp_valid_o);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL latency_2 valid=%b data=%h required valid=1 data=deadbeef", rsp_valid_o, rsp_rdata_o);
        end
        drain();
        checks++;
        if (rsp_cnt - base != 1) begin
            failures++;
            $display("FAIL wr_rd_count got=%0d required=1", rsp_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int base;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), DW'(i * 3), w);
        rsp_cyc_q.delete();
        base = rsp_cnt;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, AW'(i), '0, w);
            checks++;
            if (w != 0) begin
                failures++;
                $display("FAIL b2b_ready addr=%0d waited=%0d required=0", i, w);
            end
        end
        drain();
        checks++;
        if (rsp_cnt - base != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=8", rsp_cnt - base);
        end
        for (int i = 1; i < rsp_cyc_q.size(); i++) begin
            checks++;
            if (rsp_cyc_q[i] != rsp_cyc_q[i-1] + 1) begin
                failures++;
                $display("FAIL b2b_gap idx=%0d cycle=%0d required=%0d", i, rsp_cyc_q[i], rsp_cyc_q[i-1] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        int base;
        base        = rsp_cnt;
        rsp_ready_i = 1'b0;
        issue(1'b0, AW'(0), '0, w);
        issue(1'b0, AW'(1), '0, w);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = AW'(2);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall ready=%b valid=%b required ready=0 valid=1", req_ready_o, rsp_valid_o);
            end
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        issue(1'b0, AW'(2), '0, w);
        issue(1'b0, AW'(3), '0, w);
        drain();
        checks++;
        if (rsp_cnt - base != 4) begin
            failures++;
            $display("FAIL bp_count got=%0d required=4", rsp_cnt - base);
        end
    endtask

    task automatic test_write_then_read();
        int w;
        int w0;
        rsp_ready_i = 1'b1;
        w0 = wen_cnt;
        issue(1'b1, AW'('h20), 32'h1, w);
        issue(1'b0, AW'('h20), '0, w);
        drain();
        checks++;
        if (last_rsp !== 32'h1) begin
            failures++;
            $display("FAIL wtr_data got=%h required=00000001", last_rsp);
        end
        checks++;
        if (wen_cnt - w0 != 1) begin
            failures++;
            $display("FAIL wtr_wen_cycles got=%0d required=1", wen_cnt - w0);
        end
    endtask

    task automatic test_random();
        int w;
        int base;
        int nrd = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) issue(1'b1, AW'(i), DW'($urandom), w);
        base      = rsp_cnt;
        rand_done = 1'b0;
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 rsp_ready_i = ($urandom_range(0, 1) == 1);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic we;
                    we = ($urandom_range(0, 1) == 1);
                    if (!we) nrd++;
                    issue(we, AW'($urandom_range(0, 31)), DW'($urandom), w);
                end
                rand_done = 1'b1;
            end
        join
        drain();
        checks++;
        if (rsp_cnt - base != nrd) begin
            failures++;
            $display("FAIL rand_count got=%0d required=%0d", rsp_cnt - base, nrd);
        end
    endtask

    task automatic test_reset_midflight();
        int w;
        int base;
        rsp_ready_i = 1'b0;
        issue(1'b0, AW'(4), '0, w);
        issue(1'b0, AW'(5), '0, w);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || ram_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_async valid=%b ready=%b wen=%b required 0 1 0", rsp_valid_o, req_ready_o, ram_wen_o);
        end
        exp_q.delete();
        @(negedge clk);
        #2 rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        base = rsp_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (rsp_cnt != base || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_stale responses=%0d valid=%b ready=%b required 0 0 1", rsp_cnt - base, rsp_valid_o, req_ready_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_write_then_read();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
